// File: rtl/serial_subtractor_module.sv
// Multi-cycle two's-complement subtractor: Diff = A - B, DIGIT_W bits per clock through
// one shared adder slice (A + ~B + carry), reporting borrow, overflow, zero and negative.
module serial_subtractor_module #(
    parameter int N       = 32,
    parameter int DIGIT_W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         borrow_flag,
    output logic         overflow_flag,
    output logic         zero_flag,
    output logic         negative_flag
);
    localparam int STEPS  = N / DIGIT_W;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    if (DIGIT_W < 1 || (N % DIGIT_W) != 0) begin : g_bad_digit
        $error("serial_subtractor_module: DIGIT_W must be >= 1 and divide N");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic                carry;
    logic [N-1:0]        a_sh;
    logic [N-1:0]        b_sh;
    logic [N-1:0]        res;
    logic                a_sign;
    logic                b_sign;

    logic [DIGIT_W:0]         slice_sum;
    logic [N+DIGIT_W-1:0]     res_cat;
    logic [N-1:0]             res_next;

    // The concatenation keeps the MSB-side shift legal even when DIGIT_W == N.
    always_comb begin
        slice_sum = {1'b0, a_sh[DIGIT_W-1:0]} + {1'b0, ~b_sh[DIGIT_W-1:0]}
                  + {{DIGIT_W{1'b0}}, carry};
        res_cat   = {slice_sum[DIGIT_W-1:0], res};
        res_next  = res_cat[N+DIGIT_W-1:DIGIT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            step          <= '0;
            carry         <= 1'b0;
            a_sh          <= '0;
            b_sh          <= '0;
            res           <= '0;
            a_sign        <= 1'b0;
            b_sign        <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            Diff          <= '0;
            borrow_flag   <= 1'b0;
            overflow_flag <= 1'b0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        a_sign   <= A[N-1];
                        b_sign   <= B[N-1];
                        carry    <= 1'b1;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= slice_sum[DIGIT_W];
                    a_sh  <= a_sh >> DIGIT_W;
                    b_sh  <= b_sh >> DIGIT_W;
                    step  <= step + 1'b1;
                    // Sign copies are used here because the operand registers are shifted out.
                    if (step == LAST_STEP) begin
                        state         <= DONE;
                        out_valid     <= 1'b1;
                        Diff          <= res_next;
                        borrow_flag   <= ~slice_sum[DIGIT_W];
                        overflow_flag <= (a_sign != b_sign) && (res_next[N-1] != a_sign);
                        zero_flag     <= ~|res_next;
                        negative_flag <= res_next[N-1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_module.sv
// Scoreboard bench for serial_subtractor_module: several N/DIGIT_W instances, each with
// its own stimulus, plain-arithmetic reference model and output monitor.
module tb_serial_subtractor_module;
    localparam int NCH = 7;
    localparam int N_LIST [NCH] = '{8, 32, 8, 16, 16, 16, 16};
    localparam int D_LIST [NCH] = '{1, 4, 2, 1, 2, 4, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_fin = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCH; g++) begin : ch
        localparam int NN = N_LIST[g];
        localparam int DD = D_LIST[g];
        localparam int ST = NN / DD;
        typedef logic [NN+3:0] res_t;

        logic          rst_n     = 1'b0;
        logic          in_valid  = 1'b0;
        logic          out_ready = 1'b0;
        logic [NN-1:0] a         = '0;
        logic [NN-1:0] b         = '0;
        logic          in_ready, out_valid, borrow, ovf, zero, neg;
        logic [NN-1:0] diff;
        res_t          cur;
        int            or_mode = 0;
        int            n_in    = 0;
        int            n_out   = 0;
        res_t          exp_q[$];
        longint        lat_q[$];

        assign cur = {diff, borrow, ovf, zero, neg};

        serial_subtractor_module #(.N(NN), .DIGIT_W(DD)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (in_valid),
            .in_ready     (in_ready),
            .A            (a),
            .B            (b),
            .out_valid    (out_valid),
            .out_ready    (out_ready),
            .Diff         (diff),
            .borrow_flag  (borrow),
            .overflow_flag(ovf),
            .zero_flag    (zero),
            .negative_flag(neg)
        );

        task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
            check($sformatf("ch%0d(N=%0d,D=%0d) %s", g, NN, DD, nm), act, exp);
        endtask

        // Reference: true integer difference, unsigned compare, signed range test.
        function automatic res_t model(input logic [NN-1:0] x, input logic [NN-1:0] y);
            logic [NN-1:0] d;
            longint sx, sy, full, lim;
            logic o;
            d    = x - y;
            sx   = longint'($signed(x));
            sy   = longint'($signed(y));
            full = sx - sy;
            lim  = longint'(1) <<< (NN - 1);
            o    = (full >= lim) || (full < -lim);
            return {d, x < y, o, d == '0, d[NN-1]};
        endfunction

        // push: 0 = result discarded by reset, 1 = full scoreboard, 2 = latency only
        task automatic note_accept(input logic [NN-1:0] x, input logic [NN-1:0] y, input int push);
            if (push == 1) begin
                exp_q.push_back(model(x, y));
                n_in++;
            end
            if (push != 0) lat_q.push_back(longint'($time));
        endtask

        task automatic send(input logic [NN-1:0] x, input logic [NN-1:0] y, input int push);
            int w = 0;
            in_valid = 1'b1;
            a = x;
            b = y;
            do begin
                @(negedge clk);
                w++;
            end while (!in_ready && w < 300);
            if (!in_ready) chk("accept timeout", 64'(0), 64'(1));
            else note_accept(x, y, push);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = NN'($urandom);
            b = NN'($urandom);
        endtask

        task automatic wait_result(input res_t e, input string nm);
            int w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!out_valid && w < 100);
            chk({nm, " out_valid"}, 64'(out_valid), 64'(1));
            chk(nm, 64'(cur), 64'(e));
        endtask

        task automatic start_reset();
            rst_n = 1'b0;
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("reset out_valid", 64'(out_valid), 64'(0));
            chk("reset in_ready", 64'(in_ready), 64'(0));
            chk("reset outputs", 64'(cur), 64'(0));
            #2 rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("in_ready after release", 64'(in_ready), 64'(1));
        endtask

        task automatic rand_ops(input int n);
            logic [NN-1:0] x, y;
            or_mode = 1;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                x = NN'($urandom);
                case ($urandom_range(0, 7))
                    0:       y = x;
                    1:       y = '0;
                    2:       y = '1;
                    default: y = NN'($urandom);
                endcase
                send(x, y, 1);
            end
        endtask

        task automatic finish_ch();
            int w = 0;
            or_mode = 0;
            while (n_out != n_in && w < 300) begin
                @(negedge clk);
                w++;
            end
            chk("ops in vs out", 64'(n_out), 64'(n_in));
            n_fin++;
        endtask

        initial begin
            forever begin
                @(posedge clk);
                #1;
                if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
                else if (or_mode == 0) out_ready = 1'b1;
            end
        end

        initial begin
            logic pv, pr;
            res_t pres;
            longint t0;
            pv = 1'b0;
            pr = 1'b0;
            pres = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    pv = 1'b0;
                end else begin
                    if (pv && !pr) begin
                        chk("valid held", 64'(out_valid), 64'(1));
                        chk("result held", 64'(cur), 64'(pres));
                    end
                    if (out_valid) begin
                        chk("in_ready low in DONE", 64'(in_ready), 64'(0));
                        if (!pv) begin
                            if (lat_q.size() == 0) chk("unexpected out_valid", 64'(1), 64'(0));
                            else begin
                                t0 = lat_q.pop_front();
                                chk("latency", 64'((longint'($time) - t0) / 10 - 1), 64'(ST));
                            end
                        end
                        if (out_ready) begin
                            if (exp_q.size() == 0) chk("unexpected result", 64'(1), 64'(0));
                            else chk("result", 64'(cur), 64'(exp_q.pop_front()));
                            n_out++;
                        end
                    end
                    pv = out_valid;
                    pr = out_ready;
                    pres = cur;
                end
            end
        end

        if (g == 0) begin : d0
            initial begin
                start_reset();
                send(8'h5A, 8'h11, 1);
                wait_result({8'h49, 4'b0000}, "5A-11");
                send(8'h00, 8'h01, 1);
                wait_result({8'hFF, 4'b1001}, "00-01");
                send(8'h80, 8'h01, 1);
                wait_result({8'h7F, 4'b0100}, "80-01");
                // abort an operation at step 3
                send(8'h5A, 8'h11, 0);
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("midrun rst out_valid", 64'(out_valid), 64'(0));
                chk("midrun rst in_ready", 64'(in_ready), 64'(0));
                chk("midrun rst outputs", 64'(cur), 64'(0));
                @(posedge clk);
                #3 rst_n = 1'b1;
                #1;
                chk("in_ready before first edge", 64'(in_ready), 64'(0));
                @(posedge clk);
                #1;
                chk("in_ready after midrun release", 64'(in_ready), 64'(1));
                repeat (12) @(posedge clk);
                #1;
                // abort a result held in DONE
                or_mode = 2;
                out_ready = 1'b0;
                send(8'h00, 8'h01, 2);
                wait_result({8'hFF, 4'b1001}, "held 00-01");
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                chk("done rst out_valid", 64'(out_valid), 64'(0));
                chk("done rst outputs", 64'(cur), 64'(0));
                @(posedge clk);
                #3 rst_n = 1'b1;
                or_mode = 0;
                @(posedge clk);
                #1;
                rand_ops(100);
                finish_ch();
            end
        end else if (g == 1) begin : d1
            initial begin
                start_reset();
                send(32'hDEADBEEF, 32'hDEADBEEF, 1);
                wait_result({32'h0, 4'b0010}, "DEADBEEF equal");
                rand_ops(100);
                finish_ch();
            end
        end else if (g == 2) begin : d2
            initial begin
                start_reset();
                or_mode = 2;
                out_ready = 1'b0;
                send(8'h5A, 8'h11, 1);
                wait_result({8'h49, 4'b0000}, "bp 5A-11");
                in_valid = 1'b1;
                a = 8'hC3;
                b = 8'h3C;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp in_ready", 64'(in_ready), 64'(0));
                    chk("bp out_valid", 64'(out_valid), 64'(1));
                    chk("bp hold", 64'(cur), 64'({8'h49, 4'b0000}));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("bp release out_valid", 64'(out_valid), 64'(0));
                chk("bp release in_ready", 64'(in_ready), 64'(1));
                note_accept(8'hC3, 8'h3C, 1);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                or_mode = 0;
                wait_result({8'h87, 4'b0001}, "C3-3C after bp");
                rand_ops(100);
                finish_ch();
            end
        end else begin : dr
            initial begin
                start_reset();
                rand_ops(1000);
                finish_ch();
            end
        end
    end

    initial begin
        for (int c = 0; c < 90000 && n_fin < NCH; c++) @(posedge clk);
        if (n_fin < NCH) check("channels finished", 64'(n_fin), 64'(NCH));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_module.md
Name: serial_subtractor_module

Overview:
- Multi-cycle N-bit two's-complement subtractor; computes Diff = A - B, the inverse operation of the team's ripple-carry adder.
- Processes DIGIT_W bits per clock through a shared DIGIT_W-bit adder slice (A + ~B + carry), trading latency for area.
- Sits on the ALU datapath next to the adders.
- Reports the carry, overflow and zero flags the adders leave unimplemented, plus negative.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- N, 32: operand and result width in bits.
- DIGIT_W, 1: bits processed per cycle.
  - Must be >= 1 and must divide N; any other value is an elaboration error.
  - STEPS = N/DIGIT_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A, B are valid
- in_ready  output  1  block can accept operands
- A  input  N  minuend
- B  input  N  subtrahend
- out_valid  output  1  Diff and flags are valid
- out_ready  input  1  consumer accepts result
- Diff  output  N  A - B modulo 2^N
- borrow_flag  output  1  1 when unsigned A < B (inverted final carry)
- overflow_flag  output  1  signed overflow
- zero_flag  output  1  Diff == 0
- negative_flag  output  1  Diff[N-1]

Behaviour:
- Reset is asynchronous: rst_n low forces the following at once, regardless of clk:
  - state = IDLE, step counter = 0, carry = 0
  - operand and result registers = 0
  - in_ready = 0 while rst_n is low, 1 from the first cycle after release
  - out_valid = 0, Diff = 0, all flags = 0
- Reset during RUN or DONE discards the operation. No result is produced.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On an edge with in_valid & in_ready:
    - capture A and B into shift registers
    - carry <= 1
    - step <= 0
    - go to RUN
  - RUN: in_ready = 0, out_valid = 0. Each edge:
    - takes the low DIGIT_W bits of the A and B shift registers
    - computes the sum of the A bits, the inverted B bits and carry
    - shifts the sum into the result register from the MSB side
    - updates carry and shifts both operand registers right by DIGIT_W
    - step increments
    - on the edge where step == STEPS-1, go to DONE
  - DONE: out_valid = 1, in_ready = 0.
    - Diff and flags stay stable until out_valid & out_ready.
    - On that edge, go to IDLE; out_valid falls and in_ready rises the following cycle.
- Latency:
  - out_valid rises exactly STEPS cycles after the accepting edge.
  - Throughput is one operation per STEPS+2 cycles at best: IDLE and DONE each take one cycle minimum.
  - There is no overlap between operations.
- Flags are computed on the edge that enters DONE and registered with Diff:
  - borrow_flag = ~carry_out of the MSB digit.
  - overflow_flag = (A[N-1] != B[N-1]) & (Diff[N-1] != A[N-1]), using the captured original operand MSBs. Keep a copy of both sign bits; the shifts destroy them.
  - zero_flag = ~|Diff.
  - negative_flag = Diff[N-1].
- Boundary conditions:
  - in_valid while RUN or DONE: ignored; A and B are not sampled.
  - out_ready held high continuously: the result is consumed the first cycle out_valid is high.
  - out_ready high while out_valid is low: no effect.
  - in_valid may be dropped or changed at any time outside an accepting edge.
  - DIGIT_W == N: STEPS = 1, so RUN lasts one cycle.
  - A == B: Diff = 0, zero_flag = 1, borrow_flag = 0.
- Diff and flags hold their last value in IDLE. They are qualified only by out_valid.

Test Plan:
- Reset:
  - Assert rst_n low mid-RUN (N=8, DIGIT_W=1, A=8'h5A, B=8'h11, at step 3) -> out_valid, Diff and flags drop to 0 immediately, without waiting for clk.
  - Release rst_n -> in_ready is 1 from the next cycle.
  - No result ever appears for that operation.
- Basic subtract and latency (N=8, DIGIT_W=1):
  - A=8'h5A, B=8'h11 -> out_valid exactly 8 cycles after acceptance.
  - Diff=8'h49, borrow=0, overflow=0, zero=0, negative=0.
- Borrow and signed overflow (N=8, DIGIT_W=1):
  - A=8'h00, B=8'h01 -> Diff=8'hFF, borrow=1, negative=1, overflow=0.
  - A=8'h80, B=8'h01 -> Diff=8'h7F, overflow=1, borrow=0.
- Zero result and multi-bit digit (N=32, DIGIT_W=4):
  - A=B=32'hDEADBEEF -> Diff=0, zero=1, borrow=0.
  - out_valid exactly 8 cycles after acceptance.
- Result backpressure and ignored input (N=8, DIGIT_W=2):
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> Diff and flags stable, in_ready=0, new operands not taken.
  - Raise out_ready -> IDLE next cycle, then the new operands are accepted.
- Randomized back-to-back (N=16, DIGIT_W=1, 2, 4, 16):
  - 1000 random A/B pairs with random out_ready -> every Diff and flag matches the reference model.
  - Operation count in equals count out.
